// File: rtl/gf180mcu_fd_sc_mcu7t5v0__addf_seracc_pkg.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__addf_seracc_pkg
//
// Shared definitions for the bit-serial accumulating full adder:
//   - legal operand width bounds
//   - FSM state encoding constants and the state enum built from them
//   - helper that sizes the bit counter for a given operand width
// -----------------------------------------------------------------------------
package gf180mcu_fd_sc_mcu7t5v0__addf_seracc_pkg;

    // Operand width bounds accepted by the serial adder.
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // State encodings, kept as named constants so the enum and any
    // external observer agree on the bit patterns.
    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_RUN_ENC  = 2'd1;
    localparam logic [1:0] ST_DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_RUN  = ST_RUN_ENC,
        ST_DONE = ST_DONE_ENC
    } state_t;

    // Bit counter width: enough to index bits 0..width-1.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

    // True when the operand width lies inside the supported range.
    function automatic bit width_ok(input int width);
        return (width >= WIDTH_MIN) && (width <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__addf_seracc_func.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__addf_func
//
// Single-bit full adder slice used by the serial adder. Purely combinational.
//
// Ports:
//   A, B  in   addend bits
//   CI    in   carry in
//   S     out  sum bit       = A ^ B ^ CI
//   CO    out  carry out     = majority(A, B, CI)
// -----------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__addf_func (
    input  logic A,
    input  logic B,
    input  logic CI,
    output logic S,
    output logic CO
);

    logic half_sum;

    assign half_sum = A ^ B;
    assign S        = half_sum ^ CI;
    // Generate when both addends are set, propagate the incoming carry
    // when exactly one of them is.
    assign CO       = (A & B) | (CI & half_sum);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__addf_seracc.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__addf_seracc
//
// Bit-serial adder: one full-adder slice, a carry flop and LSB-first shift
// registers for A, B and the sum. An operand word is accepted in IDLE,
// processed one bit per clock in RUN (WIDTH edges), and the result is held
// in DONE until the consumer takes it with OUT_READY.
//
// Ports:
//   VDD, VSS   inout  power pins (only with USE_POWER_PINS)
//   CLK        in     clock, rising edge
//   RN         in     asynchronous active-low reset
//   IN_VALID   in     operand word A/B/CI_IN valid
//   IN_READY   out    block idle and able to accept an operand word
//   A, B       in     WIDTH-bit addends
//   CI_IN      in     initial carry-in
//   OUT_VALID  out    S/CO hold a completed sum
//   OUT_READY  in     downstream consumes the result
//   S          out    registered WIDTH-bit sum
//   CO         out    registered final carry-out
//
// Latency: OUT_VALID rises WIDTH edges after the accepting edge. With
// OUT_READY held high the block accepts a new word every WIDTH+2 edges.
// S/CO only update on entry to DONE, so they keep the previous result
// while a new operation runs and after the handshake back to IDLE.
// -----------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__addf_seracc
    import gf180mcu_fd_sc_mcu7t5v0__addf_seracc_pkg::*;
#(
    parameter int WIDTH = 8
) (
`ifdef USE_POWER_PINS
    inout  wire              VDD,
    inout  wire              VSS,
`endif
    input  logic             CLK,
    input  logic             RN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI_IN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] S,
    output logic             CO
);

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    // Elaboration-time guard on the operand width.
    if (!width_ok(WIDTH)) begin : g_width_check
        $error("addf_seracc: WIDTH must lie in 2..32");
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-1:0] s_q;
    logic             co_q;
    logic             out_valid_q;

    // -------------------------------------------------------------------------
    // Bit slice: carry flop drives CI, slice CO feeds the carry flop.
    // -------------------------------------------------------------------------
    logic sum_bit;
    logic co_bit;

    gf180mcu_fd_sc_mcu7t5v0__addf_func u_slice (
        .A  (a_sr[0]),
        .B  (b_sr[0]),
        .CI (carry),
        .S  (sum_bit),
        .CO (co_bit)
    );

    // Sum register after this edge's bit enters at the MSB. After WIDTH
    // shifts bit 0 of the result has travelled down to s_sr[0].
    logic [WIDTH-1:0] s_shift;
    assign s_shift = {sum_bit, {(WIDTH-1){1'b0}}} | (s_sr >> 1);

    // -------------------------------------------------------------------------
    // Sequential logic: FSM, datapath and output registers in one process.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state       <= ST_IDLE;
            // NOTE: the shift registers are reset as well, so an operation
            // aborted by reset leaves no partial operand or sum behind.
            a_sr        <= '0;
            b_sr        <= '0;
            s_sr        <= '0;
            cnt         <= '0;
            carry       <= 1'b0;
            s_q         <= '0;
            co_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments everywhere here, so every flop
            // sees the pre-edge value of every other flop.
            case (state)
                ST_IDLE: begin
                    // Operands are sampled only on this accepting edge.
                    if (IN_VALID) begin
                        a_sr  <= A;
                        b_sr  <= B;
                        carry <= CI_IN;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    s_sr  <= s_shift;
                    carry <= co_bit;
                    if (cnt == CNT_LAST) begin
                        // Last bit: publish the result together with OUT_VALID.
                        // The counter stops here rather than wrapping.
                        s_q         <= s_shift;
                        co_q        <= co_bit;
                        out_valid_q <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                ST_DONE: begin
                    if (OUT_READY) begin
                        out_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: all driven from flops, no input-to-output combinational path.
    // -------------------------------------------------------------------------
    assign IN_READY  = (state == ST_IDLE);
    assign OUT_VALID = out_valid_q;
    assign S         = s_q;
    assign CO        = co_q;

`ifndef SYNTHESIS
    // OUT_VALID flop must mirror the DONE state.
    a_valid_is_done: assert property (@(posedge CLK) disable iff (!RN)
        OUT_VALID == (state == ST_DONE));

    // The bit counter never runs past the last bit index.
    a_cnt_bounded: assert property (@(posedge CLK) disable iff (!RN)
        (state == ST_RUN) |-> (cnt <= CNT_LAST));
`endif

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__addf_seracc.md
GF180MCU_FD_SC_MCU7T5V0__ADDF_SERACC -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__addf_seracc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port RN  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port IN_VALID  input  1  operand word A/B/CI_IN valid.
REQ-005 SHALL have port IN_READY  output  1  block can accept an operand word.
REQ-006 SHALL have port A  input  WIDTH  addend A.
REQ-007 SHALL have port B  input  WIDTH  addend B.
REQ-008 SHALL have port CI_IN  input  1  initial carry-in.
REQ-009 SHALL have port OUT_VALID  output  1  S/CO hold a completed sum.
REQ-010 SHALL have port OUT_READY  input  1  downstream consumes result.
REQ-011 SHALL have port S  output  WIDTH  sum, registered.
REQ-012 SHALL have port CO  output  1  final carry-out, registered.
REQ-013 SHALL have ports VDD, VSS  inout  1  power pins, present only under USE_POWER_PINS.

Function
REQ-014 SHALL implement a bit-serial adder: one full-adder slice, a carry flop, and LSB-first shift registers for A, B and S.
REQ-015 SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-016 IN_READY SHALL be 1 exactly when state is IDLE, decoded from registered state.
REQ-017 In IDLE, IN_VALID=1 at a rising edge SHALL load A, B into shift registers, load carry with CI_IN, clear bit counter, and enter RUN.
REQ-018 In IDLE, IN_VALID=0 SHALL leave all state unchanged.
REQ-019 In RUN, each edge SHALL add A_sr[0], B_sr[0], carry; shift the sum bit into S_sr MSB; shift A_sr and B_sr right; set carry to the slice carry-out; increment the counter.
REQ-020 Counter width SHALL be clog2(WIDTH); RUN SHALL exit to DONE on the edge that processes bit WIDTH-1, with no wrap-around beyond WIDTH-1.
REQ-021 OUT_VALID SHALL rise exactly WIDTH rising edges after the accepting edge.
REQ-022 In DONE, OUT_VALID SHALL be 1, and S = (A+B+CI_IN) mod 2^WIDTH and CO = bit WIDTH of that sum SHALL be held stable.
REQ-023 In DONE, OUT_READY=1 at an edge SHALL return to IDLE, and OUT_VALID SHALL fall; OUT_READY=0 SHALL hold DONE indefinitely.
REQ-024 S and CO SHALL keep the last result after returning to IDLE, until the next DONE.
REQ-025 IN_VALID outside IDLE SHALL be ignored; A/B/CI_IN SHALL be sampled only on the accepting edge.
REQ-026 OUT_READY outside DONE SHALL be ignored.
REQ-027 There SHALL be no combinational path from any input to any output.
REQ-028 Throughput SHALL be one operation per WIDTH+2 cycles minimum (accept, WIDTH RUN edges, handshake).

Reset
REQ-029 RN=0 SHALL immediately force state IDLE, IN_READY=1, OUT_VALID=0, S=0, CO=0, and clear carry, counter and all shift registers.
REQ-030 Reset asserted mid-RUN or in DONE SHALL discard the operation in progress with no partial result retained.
REQ-031 The first accept SHALL be possible on the first rising edge with RN=1.

Structure
REQ-032 The FSM state enum, state encoding constants and WIDTH bounds SHALL live in a shared package.
REQ-033 The bit slice SHALL be one sub-module instance, gf180mcu_fd_sc_mcu7t5v0__addf_func, with its CO feeding the carry flop and the carry flop driving its CI.
REQ-034 All flops SHALL be in a single clocked process with RN in its sensitivity list.

Verification (WIDTH=8)
REQ-035 The bench SHALL cover: A=0xFF, B=0x01, CI_IN=0, OUT_READY=1 -> OUT_VALID after 8 edges, S=0x00, CO=1, IDLE one edge later.
REQ-036 The bench SHALL cover: A=0x5A, B=0xA5, CI_IN=1 -> S=0x00, CO=1; then A=0x12, B=0x34, CI_IN=0 -> S=0x46, CO=0.
REQ-037 The bench SHALL cover: OUT_READY=0 for 5 cycles in DONE -> OUT_VALID and S stay stable, IN_READY=0; new IN_VALID with A=0x01 is ignored.
REQ-038 The bench SHALL cover: RN pulsed low after the 4th RUN edge of A=0xF0, B=0x0F -> outputs immediately zero, IN_READY=1, no OUT_VALID; the next op A=0x03, B=0x04 gives S=0x07.
REQ-039 The bench SHALL cover: back-to-back IN_VALID held high with OUT_READY=1 -> accepts spaced exactly 10 cycles apart.
REQ-040 The bench SHALL cover: 1000 random A/B/CI_IN with random OUT_READY -> S/CO match the reference sum every transaction.
